resource_arbiter: RTL

RESOURCE_ARBITER -- requirements
Module: resource_arbiter

---
 rtl/resource_arbiter_pkg.sv | 27 ++
 rtl/resource_arbiter_rr_pick.sv | 27 ++
 rtl/resource_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/resource_arbiter_pkg.sv
// Shared defaults, FSM state encoding and the in-flight tag record for the
// round-robin resource arbiter.
package resource_arbiter_pkg;

   localparam int DEF_N_REQ    = 4;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_RES_LAT  = 2;
   localparam int DEF_MAX_HOLD = 8;

   // Wide enough for the largest supported requester count (8).
   localparam int OWNER_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic               valid;
      logic [OWNER_W-1:0] owner;
   } tag_t;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/resource_arbiter_rr_pick.sv
// Round-robin search: first set request bit at or after start, wrapping at N_REQ.
module resource_arbiter_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] winner,
   output logic             found
);

   // Scan from the farthest offset down so the nearest hit is written last.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(start) + k) % N_REQ;
         if (req[idx]) begin
            winner = IDX_W'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/resource_arbiter.sv
// Round-robin arbiter sharing one fixed-latency resource among N_REQ pipelines,
// with a hold limit and a tag pipeline that routes each result back to its issuer.
module resource_arbiter
   import resource_arbiter_pkg::*;
#(
   parameter int N_REQ    = DEF_N_REQ,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int RES_LAT  = DEF_RES_LAT,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        grant,
   output logic [DATA_W-1:0]       res_in,
   output logic                    res_in_valid,
   input  logic [DATA_W-1:0]       res_out,
   output logic [DATA_W-1:0]       resp_data,
   output logic [N_REQ-1:0]        resp_valid
);

   localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

   arb_state_t        state, state_n;
   logic [IDX_W-1:0]  owner, owner_n, ptr, ptr_n, owner_inc;
   logic [IDX_W-1:0]  pick_start, pick_idx;
   logic              pick_found;
   logic [N_REQ-1:0]  pick_req, others;
   logic [HOLD_W-1:0] hold_cnt, hold_n;
   tag_t              tag_pipe [RES_LAT];
   tag_t              tag_tail;

   assign owner_inc  = IDX_W'(wrap_inc(int'(owner), N_REQ));
   assign others     = req & ~(N_REQ'(1) << owner);
   // Idle searches from ptr; an owner hands off starting just past itself.
   assign pick_req   = (state == IDLE) ? req : others;
   assign pick_start = (state == IDLE) ? ptr : owner_inc;

   resource_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req    (pick_req),
      .start  (pick_start),
      .winner (pick_idx),
      .found  (pick_found)
   );

   always_comb begin
      state_n = state;
      owner_n = owner;
      ptr_n   = ptr;
      hold_n  = hold_cnt;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_n = OWNED;
               owner_n = pick_idx;
               hold_n  = '0;
            end
         end
         OWNED: begin
            if (!req[owner]) begin
               hold_n = '0;
               if (pick_found) begin
                  owner_n = pick_idx;
               end else begin
                  state_n = IDLE;
                  ptr_n   = owner_inc;
               end
            end else if (hold_cnt == HOLD_MAX) begin
               // Forced hand-off only when someone is waiting; otherwise saturate.
               if (pick_found) begin
                  owner_n = pick_idx;
                  hold_n  = '0;
               end
            end else begin
               hold_n = hold_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= '0;
         ptr      <= '0;
         hold_cnt <= '0;
         grant    <= '0;
      end else begin
         state    <= state_n;
         owner    <= owner_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_n;
         grant    <= (state_n == OWNED) ? (N_REQ'(1) << owner_n) : '0;
      end
   end

   assign res_in_valid = |(grant & req);
   assign res_in       = res_in_valid ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RES_LAT; i++) tag_pipe[i] <= '0;
      end else begin
         tag_pipe[0] <= '{valid: res_in_valid, owner: OWNER_W'(owner)};
         for (int i = 1; i < RES_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   assign tag_tail   = tag_pipe[RES_LAT-1];
   assign resp_valid = tag_tail.valid ? (N_REQ'(1) << tag_tail.owner) : '0;
   assign resp_data  = res_out;

endmodule
